// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings, completion codes and decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Unsigned sizes only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = rdata >> {addr_lo, 3'b000};
    be          = 4'b1111;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    case (funct3[1:0])
      2'b00: begin
        be          = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = funct3[2] ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be          = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = funct3[2] ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: decodes and checks the access, runs one
// req/gnt/rvalid bus transaction and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic [1:0]        lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  lsu_align u_align (
    .funct3      (f3_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid) begin
          if (f3_illegal(lsu_funct3, lsu_we)) begin
            err_d   = ERR_ILLEGAL;
            rdata_d = '0;
            state_d = DONE;
          end else if (f3_misaligned(lsu_funct3, lsu_addr[1:0])) begin
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            addr_d  = lsu_addr;
            we_d    = lsu_we;
            f3_d    = lsu_funct3;
            wdata_d = lsu_wdata;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = RSP;
        end
      end
      RSP: begin
        // rvalid takes priority over the timeout limit in the same cycle.
        if (mem_rvalid) begin
          rdata_d = al_rdata;
          err_d   = ERR_OK;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = ERR_TIMEOUT;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    mem_be    = mem_req ? al_be : '0;
    mem_wdata = mem_req ? al_wdata : '0;
    lsu_done  = (state_q == DONE);
    lsu_stall = lsu_valid & ~lsu_done;
    lsu_rdata = rdata_q;
    lsu_err   = err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset and
// back-to-back sequences, and randomized accesses against a reference model.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    int          done_cyc;
    logic [31:0] rdata;
    bit          chk_rdata;
    logic [31:0] addr;
    logic [3:0]  be;      // 0 means no bus activity expected
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          gnt_dly, rv_dly;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          done_cyc;
    int          reqs;
    logic [1:0]  err;
    logic [31:0] rdata, addr, wdata;
    logic [3:0]  be;
    logic        we;
    bit          stable, stall_ok, pulse_ok;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int stall_low = 0;
  int done_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: expected outcome from RV32I access rules and bus timing.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gnt_dly, input int rv_dly);
    exp_t e;
    int size, off, rsp;
    bit legal;
    longint unsigned val, mask;
    e = '{default: 0};
    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    legal = (f3 == 0 || f3 == 1 || f3 == 2) || (!we && (f3 == 4 || f3 == 5));
    if (!legal) begin
      e.err = 2'b11; e.done_cyc = 1; return e;
    end
    if ((addr % size) != 0) begin
      e.err = 2'b01; e.done_cyc = 1; return e;
    end
    off = int'(addr % 4);
    e.addr = addr - off;
    e.be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    rsp = (rv_dly >= int'(TO)) ? int'(TO) : rv_dly + 1;
    e.done_cyc = gnt_dly + 2 + rsp;
    if (rv_dly >= int'(TO)) begin
      e.err = 2'b10; e.rdata = 0; e.chk_rdata = 1;
    end else if (!we) begin
      val = 64'(rdata);
      val = val >> (8 * off);
      if (size < 4) begin
        mask = (64'd1 << (8 * size)) - 1;
        val = val & mask;
        if (!f3[2] && ((val >> (8 * size - 1)) & 1) == 1) val = val | ~mask;
      end
      e.rdata = val[31:0];
      e.chk_rdata = 1;
    end
    return e;
  endfunction

  // Presents one access in IDLE (cycle 0) and acts as the memory slave.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input bit keep, output obs_t o);
    bit granted = 0;
    bit done = 0;
    int rsp = 0;
    int cyc = 0;
    o = '{default: 0};
    o.stable = 1; o.stall_ok = 1; o.done_cyc = -1;
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    mem_rdata = rdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    if (lsu_stall !== 1'b1) o.stall_ok = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (lsu_stall !== (lsu_valid & ~lsu_done)) o.stall_ok = 0;
      if (lsu_valid && !lsu_stall) stall_low++;
      if (lsu_done) begin
        done = 1; done_pulses++;
        o.done_cyc = cyc; o.err = lsu_err; o.rdata = lsu_rdata;
      end else if (mem_req) begin
        o.reqs++;
        if (o.reqs == 1) begin
          o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
        end else if (mem_addr !== o.addr || mem_be !== o.be || mem_wdata !== o.wdata || mem_we !== o.we) begin
          o.stable = 0;
        end
        if (o.reqs > gnt_dly) begin mem_gnt = 1'b1; granted = 1; end
      end else if (granted) begin
        rsp++;
        if (rsp > rv_dly) mem_rvalid = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait actual=no_done expected=done_within_200_cycles");
    end
    @(posedge clk); #1;
    o.pulse_ok = (lsu_done === 1'b0);
    if (!keep) lsu_valid = 1'b0;
  endtask

  task automatic verify(input string tag, input logic we, input int gnt_dly, input exp_t e, input obs_t o);
    chk({tag, " done_cycle"}, o.done_cyc, e.done_cyc);
    chk({tag, " err"}, o.err, e.err);
    if (e.chk_rdata) chk({tag, " rdata"}, o.rdata, e.rdata);
    if (e.be == 4'b0000) begin
      chk({tag, " req_cycles"}, o.reqs, 0);
    end else begin
      chk({tag, " req_cycles"}, o.reqs, gnt_dly + 1);
      chk({tag, " mem_addr"}, o.addr, e.addr);
      chk({tag, " mem_be"}, o.be, e.be);
      chk({tag, " mem_we"}, o.we, we);
      if (we) chk({tag, " mem_wdata"}, o.wdata, e.wdata);
      chk({tag, " bus_stable"}, o.stable, 1);
    end
    chk({tag, " stall"}, o.stall_ok, 1);
    chk({tag, " done_pulse_one_cycle"}, o.pulse_ok, 1);
  endtask

  function automatic vec_t mkvec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gd, input int rd, input logic [1:0] err, input int dc,
                                 input logic [31:0] erd, input bit crd, input logic [31:0] eaddr,
                                 input logic [3:0] ebe, input logic [31:0] ewd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gnt_dly = gd; v.rv_dly = rd;
    v.e.err = err; v.e.done_cyc = dc; v.e.rdata = erd; v.e.chk_rdata = crd;
    v.e.addr = eaddr; v.e.be = ebe; v.e.wdata = ewd;
    return v;
  endfunction

  vec_t vecs[14];
  obs_t o;
  exp_t e;
  int   stray;

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_be", mem_be, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset lsu_done", lsu_done, 0);
    chk("reset lsu_rdata", lsu_rdata, 0);
    chk("reset lsu_err", lsu_err, 0);
    rst = 1'b0;

    //               we    f3      addr          wdata         rdata        gd rv    err    dc  rdata         crd addr          be       wdata
    vecs[0]  = mkvec(1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80AB_CDEF, 0, 0,    2'b00, 3,  32'hFFFF_FF80, 1, 32'h0000_1000, 4'b1000, 32'h0);
    vecs[1]  = mkvec(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h0,        3, 0,    2'b00, 6,  32'h0,         0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    vecs[2]  = mkvec(1'b0, 3'b101, 32'h0000_3002, 32'h0,        32'h8001_7FFF, 0, 0,    2'b00, 3,  32'h0000_8001, 1, 32'h0000_3000, 4'b1100, 32'h0);
    vecs[3]  = mkvec(1'b0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 0,    2'b01, 1,  32'h0,         0, 32'h0,         4'b0000, 32'h0);
    vecs[4]  = mkvec(1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'h1111_2222, 0, 1000, 2'b10, 18, 32'h0,         1, 32'h0000_4000, 4'b1111, 32'h0);
    vecs[5]  = mkvec(1'b1, 3'b100, 32'h0000_5000, 32'hFF,       32'h0,         0, 0,    2'b11, 1,  32'h0,         0, 32'h0,         4'b0000, 32'h0);
    vecs[6]  = mkvec(1'b0, 3'b010, 32'h0000_4010, 32'h0,        32'h1357_9BDF, 0, 15,   2'b00, 18, 32'h1357_9BDF, 1, 32'h0000_4010, 4'b1111, 32'h0);
    vecs[7]  = mkvec(1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,        1, 2,    2'b00, 6,  32'h0,         0, 32'h0000_5004, 4'b1111, 32'hCAFE_F00D);
    vecs[8]  = mkvec(1'b0, 3'b001, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 0, 0,    2'b00, 3,  32'hFFFF_8001, 1, 32'h0000_6000, 4'b1100, 32'h0);
    vecs[9]  = mkvec(1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 32'h0,        0, 0,    2'b00, 3,  32'h0,         0, 32'h0000_7000, 4'b0010, 32'hA5A5_A5A5);
    vecs[10] = mkvec(1'b0, 3'b011, 32'h0000_8000, 32'h0,        32'h0,         0, 0,    2'b11, 1,  32'h0,         0, 32'h0,         4'b0000, 32'h0);
    vecs[11] = mkvec(1'b0, 3'b100, 32'h0000_8001, 32'h0,        32'h1234_F0AA, 0, 0,    2'b00, 3,  32'h0000_00F0, 1, 32'h0000_8000, 4'b0010, 32'h0);
    vecs[12] = mkvec(1'b0, 3'b010, 32'h0000_4020, 32'h0,        32'h5555_AAAA, 0, 16,   2'b10, 18, 32'h0,         1, 32'h0000_4020, 4'b1111, 32'h0);
    vecs[13] = mkvec(1'b1, 3'b001, 32'h0000_9001, 32'hFFFF,     32'h0,         0, 0,    2'b01, 1,  32'h0,         0, 32'h0,         4'b0000, 32'h0);

    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              vecs[i].gnt_dly, vecs[i].rv_dly, 1'b0, o);
      verify($sformatf("vec%0d", i), vecs[i].we, vecs[i].gnt_dly, vecs[i].e, o);
    end

    // Reset held for two cycles while waiting in RSP; stray rvalid afterwards.
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("rstmid req_seen", mem_req, 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; lsu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid mem_req", mem_req, 0);
    chk("rstmid lsu_done", lsu_done, 0);
    chk("rstmid lsu_err", lsu_err, 0);
    chk("rstmid lsu_stall", lsu_stall, 0);
    mem_rvalid = 1'b1;
    stray = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (lsu_done || mem_req) stray++;
    end
    mem_rvalid = 1'b0;
    chk("rstmid stray_rvalid_activity", stray, 0);

    // Back-to-back LW then SW with lsu_valid held between them.
    stall_low = 0; done_pulses = 0;
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b1, o);
    e = model(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, 0, 0);
    verify("b2b_lw", 1'b0, 0, e, o);
    run_txn(1'b1, 3'b010, 32'h104, 32'h7654_3210, 32'h0, 0, 0, 1'b0, o);
    e = model(1'b1, 3'b010, 32'h104, 32'h7654_3210, 32'h0, 0, 0);
    verify("b2b_sw", 1'b1, 0, e, o);
    chk("b2b done_pulses", done_pulses, 2);
    chk("b2b stall_low_cycles", stall_low, 2);

    for (int n = 0; n < 150; n++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd, r_rd;
      int          r_gd, r_rv, sel;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 9) < 5) r_addr[1:0] = 2'b00;
      r_wd = $urandom;
      r_rd = $urandom;
      r_gd = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      r_rv = (sel < 6) ? $urandom_range(0, 3) : (sel == 6) ? TO - 1 : (sel == 7) ? TO
           : $urandom_range(0, TO + 3);
      run_txn(r_we, r_f3, r_addr, r_wd, r_rd, r_gd, r_rv, 1'($urandom_range(0, 1)), o);
      e = model(r_we, r_f3, r_addr, r_wd, r_rd, r_gd, r_rv);
      verify($sformatf("rnd%0d", n), r_we, r_gd, e, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
